mul_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit downstream of the register bank; consumes the
//  two read operands (DR1 -> A, DR2 -> B) and produces a 64-bit HI/LO result.

---
 rtl/mul_div_unit_if.sv | 14 +
 rtl/mul_div_unit.sv | 134 +++++++++++++
 tb/tb_mul_div_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// mdu_if: request/result bundle between the control unit and mul_div_unit
interface mdu_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  modport master (output Start, Op, A, B, input Busy, Done, DivZero, HI, LO);
  modport slave (input Start, Op, A, B, output Busy, Done, DivZero, HI, LO);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: shift-add multiplier / restoring divider on one datapath; MDU_SIGNED_EN enables signed MULT/DIV via Op[0]
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d, dz_q, dz_d;
  logic               busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;
  logic [WIDTH-1:0]   b_q, b_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mag_a, mag_b, r_fix, q_fix;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic               accept;
  assign accept   = (state_q == IDLE) & bus.Start;
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  assign div_diff = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, b_q};
`ifdef MDU_SIGNED_EN
  logic sa, sb, neg_p_q, neg_p_d, neg_r_q, neg_r_d;
  assign sa    = bus.Op[0] & bus.A[WIDTH-1];
  assign sb    = bus.Op[0] & bus.B[WIDTH-1];
  assign mag_a = sa ? -bus.A : bus.A;
  assign mag_b = sb ? -bus.B : bus.B;
  assign prod  = neg_p_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign r_fix = neg_r_q ? -acc_hi_q : acc_hi_q;
  assign q_fix = neg_p_q ? -acc_lo_q : acc_lo_q;
  // Result/remainder sign flags, captured only when a request is accepted
  always_comb begin
    neg_p_d = accept ? sa ^ sb : neg_p_q;
    neg_r_d = accept ? sa : neg_r_q;
  end
  // Sign flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  logic unused_op;
  assign unused_op = bus.Op[0];
  assign mag_a     = bus.A;
  assign mag_b     = bus.B;
  assign prod      = {acc_hi_q, acc_lo_q};
  assign r_fix     = acc_hi_q;
  assign q_fix     = acc_lo_q;
`endif
  // Next-state and datapath: latch on accept, iterate WIDTH times, then correct and publish
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    dz_d      = dz_q;
    b_d       = b_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
    case (state_q)
      IDLE: if (bus.Start) begin
        state_d  = CALC;
        busy_d   = 1'b1;
        cnt_d    = '0;
        div_d    = bus.Op[1];
        dz_d     = bus.Op[1] & (bus.B == '0);
        b_d      = mag_b;
        acc_hi_d = '0;
        acc_lo_d = mag_a;
      end
      CALC: begin
        cnt_d    = cnt_q + 1'b1;
        acc_hi_d = div_q ? (div_diff[WIDTH] ? {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]} : div_diff[WIDTH-1:0])
                         : mul_sum[WIDTH:1];
        acc_lo_d = div_q ? {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]} : {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        state_d  = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
      end
      FIX: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        done_d       = 1'b1;
        divzero_d    = dz_q;
        {hi_d, lo_d} = div_q ? {r_fix, (dz_q ? {WIDTH{1'b1}} : q_fix)} : prod;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers; reset aborts any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      b_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      dz_q      <= dz_d;
      b_q       <= b_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = divzero_q;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  always #5 clk = ~clk;
  mdu_if #(.WIDTH(32)) bif ();
  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bif));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Reference: {DivZero, HI, LO} from plain arithmetic
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    longint x, y;
    longint unsigned ux, uy;
    int sa, sb;
`ifdef MDU_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    if (!op[1]) begin
      if (sgn) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        return {1'b0, 64'(x * y)};
      end
      ux = 64'(a);
      uy = 64'(b);
      return {1'b0, ux * uy};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      return {1'b0, 32'(sa % sb), 32'(sa / sb)};
    end
    return {1'b0, a % b, a / b};
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  // inj: 0 plain, 1 Start pulse mid-CALC, 2 Start held across the FIX edge
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    logic [64:0] e;
    logic [63:0] hl0;
    int k, bc, extra;
    e = model(op, a, b);
    @(negedge clk);
    bif.Start = 1'b1; bif.Op = op; bif.A = a; bif.B = b;
    @(posedge clk); #1;
    bif.Start = 1'b0; bif.A = $urandom; bif.B = $urandom; bif.Op = 2'($urandom);
    hl0 = {bif.HI, bif.LO};
    chk("busy_on", 64'(bif.Busy), 64'd1);
    bc = 1;
    k = 0;
    while (!bif.Done && k < 40) begin
      @(posedge clk); #1;
      k++;
      bc += int'(bif.Busy);
      if (inj == 1 && k == 10) begin bif.Start = 1'b1; bif.A = 32'd2; bif.B = 32'd2; end
      if (inj == 1 && k == 11) bif.Start = 1'b0;
      if (k == 16) chk("hold_during_calc", {bif.HI, bif.LO}, hl0);
      if (inj == 2 && k == 32) bif.Start = 1'b1;
    end
    bif.Start = 1'b0;
    chk("latency", 64'(k), 64'd33);
    chk("busy_cycles", 64'(bc), 64'd33);
    chk("hi", 64'(bif.HI), 64'(e[63:32]));
    chk("lo", 64'(bif.LO), 64'(e[31:0]));
    chk("divzero", 64'(bif.DivZero), 64'(e[64]));
    chk("busy_off", 64'(bif.Busy), 64'd0);
    @(posedge clk); #1;
    chk("done_pulse", 64'(bif.Done), 64'd0);
    if (inj != 0) begin
      extra = 0;
      repeat (40) begin
        @(posedge clk); #1;
        extra += int'(bif.Busy) + int'(bif.Done);
      end
      chk("start_ignored", 64'(extra), 64'd0);
      chk("result_kept", {bif.HI, bif.LO}, e[63:0]);
    end
  endtask
  initial begin
    int extra;
    bif.Start = 1'b0; bif.Op = 2'd0; bif.A = '0; bif.B = '0;
    #12;
    chk("rst_outputs", {29'd0, bif.Busy, bif.Done, bif.DivZero, bif.HI, bif.LO}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b00, 32'd7, 32'd6, 0);
    chk("t1_lo", 64'(bif.LO), 64'd42);
    chk("t1_hi", 64'(bif.HI), 64'd0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(2'b10, 32'd100, 32'd7, 0);
    chk("t3_lo", 64'(bif.LO), 64'd14);
    chk("t3_hi", 64'(bif.HI), 64'd2);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b10, 32'h1234, 32'd0, 0);
    run_op(2'b11, 32'hFFFF_FFF0, 32'd0, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'd7, 32'd6, 1);
    run_op(2'b10, 32'd12345, 32'd10, 2);
    @(negedge clk);
    bif.Start = 1'b1; bif.Op = 2'b10; bif.A = 32'd1000; bif.B = 32'd3;
    @(posedge clk); #1;
    bif.Start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_abort", {29'd0, bif.Busy, bif.Done, bif.DivZero, bif.HI, bif.LO}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      extra += int'(bif.Busy) + int'(bif.Done);
    end
    chk("no_done_after_abort", 64'(extra), 64'd0);
    run_op(2'b00, 32'd9, 32'd9, 0);
    chk("t6_lo", 64'(bif.LO), 64'd81);
    for (int i = 0; i < 40; i++) run_op(2'($urandom), pick(), pick(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
